cf_pulse_decoder: RTL and testbench



---
 rtl/cf_pulse_decoder.sv | 102 ++++++++++
 tb/tb_cf_pulse_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cf_pulse_decoder.sv
// Flag-line pulse decoder: measures each high pulse on cf and classifies its
// width as mode 0 (short) or mode 1 (long), flagging widths outside both windows.
module cf_pulse_decoder #(
    parameter int SHORT_LEN = 6,
    parameter int LONG_LEN  = 18,
    parameter int TOL       = 1,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cf,
    output logic             busy,
    output logic             valid,
    output logic             mode_out,
    output logic             err,
    output logic [CNT_W-1:0] len,
    output logic [7:0]       good_cnt
);

    // valid is a one-cycle strobe with no ready: a consumer must take
    // len/err/mode_out/good_cnt on the cycle valid is high; they hold until the next strobe.

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             armed;
    logic [CNT_W-1:0] count;
    logic [31:0]      cnt_ext;
    logic             in_short;
    logic             in_long;

    // Window tests are written without subtraction so they stay unsigned-safe.
    always_comb begin
        cnt_ext  = 32'(count);
        in_short = (cnt_ext + 32'(TOL) >= 32'(SHORT_LEN)) &&
                   (cnt_ext <= 32'(SHORT_LEN + TOL));
        in_long  = (cnt_ext + 32'(TOL) >= 32'(LONG_LEN)) &&
                   (cnt_ext <= 32'(LONG_LEN + TOL));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            mode_out <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
            good_cnt <= 8'd0;
        end else begin
            valid <= 1'b0;
            // A pulse already high at reset release is ignored until cf is seen low.
            if (!cf) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cf && armed) begin
                        state <= MEASURE;
                        count <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (cf) begin
                        if (count != CNT_MAX) begin
                            count <= count + CNT_ONE;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        len   <= count;
                        if (in_short) begin
                            mode_out <= 1'b0;
                            err      <= 1'b0;
                            good_cnt <= good_cnt + 8'd1;
                        end else if (in_long) begin
                            mode_out <= 1'b1;
                            err      <= 1'b0;
                            good_cnt <= good_cnt + 8'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cf_pulse_decoder.sv
// Randomized and directed bench for cf_pulse_decoder; each pulse width is
// classified by a width-based model and compared against every valid strobe.
module tb_cf_pulse_decoder;

    localparam int SHORT_LEN = 6;
    localparam int LONG_LEN  = 18;
    localparam int TOL       = 1;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             cf;
    logic             busy;
    logic             valid;
    logic             mode_out;
    logic             err;
    logic [CNT_W-1:0] len;
    logic [7:0]       good_cnt;

    int checks;
    int errors;

    // Expected result per decoded pulse: {good_cnt[7:0], mode, err, len[4:0]}
    logic [14:0] exp_q[$];
    int          exp_pushed;
    int          valid_seen;

    logic [7:0] model_good;
    logic       model_mode;

    cf_pulse_decoder #(
        .SHORT_LEN(SHORT_LEN),
        .LONG_LEN (LONG_LEN),
        .TOL      (TOL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cf      (cf),
        .busy    (busy),
        .valid   (valid),
        .mode_out(mode_out),
        .err     (err),
        .len     (len),
        .good_cnt(good_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: classify a pulse of width w by the window rules.
    task automatic model_push(input int w);
        int  l;
        logic e;
        l = (w > CNT_MAX) ? CNT_MAX : w;
        if (l >= SHORT_LEN - TOL && l <= SHORT_LEN + TOL) begin
            model_mode = 1'b0;
            model_good = model_good + 8'd1;
            e = 1'b0;
        end else if (l >= LONG_LEN - TOL && l <= LONG_LEN + TOL) begin
            model_mode = 1'b1;
            model_good = model_good + 8'd1;
            e = 1'b0;
        end else begin
            e = 1'b1;
        end
        exp_q.push_back({model_good, model_mode, e, 5'(l)});
        exp_pushed++;
    endtask

    // Scoreboard: every valid strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && valid) begin
            logic [14:0] e;
            valid_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("len", 32'(len), 32'(e[4:0]));
                check("err", 32'(err), 32'(e[5]));
                check("mode_out", 32'(mode_out), 32'(e[6]));
                check("good_cnt", 32'(good_cnt), 32'(e[14:7]));
            end
        end
    end

    // Driver: one cycle of cf, applied on the falling edge.
    task automatic drive(input logic v);
        cf = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pulse(input int w, input int gap, input bit do_busy);
        int busy_hi;
        busy_hi = 0;
        for (int i = 0; i < w; i++) begin
            drive(1'b1);
            if (busy) busy_hi++;
        end
        model_push(w);
        for (int i = 0; i < gap; i++) begin
            drive(1'b0);
            if (i == 0 && do_busy) check("busy_low_after", 32'(busy), 32'd0);
        end
        if (do_busy) check("busy_cycles", 32'(busy_hi), 32'(w));
    endtask

    task automatic apply_reset(input int cyc);
        reset = 1'b1;
        repeat (cyc) @(negedge clk);
        reset = 1'b0;
        model_good = 8'd0;
        model_mode = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int w;
        int sizes[7];
        checks     = 0;
        errors     = 0;
        exp_pushed = 0;
        valid_seen = 0;
        model_good = 8'd0;
        model_mode = 1'b0;
        cf         = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        apply_reset(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_len", 32'(len), 32'd0);
        check("rst_good", 32'(good_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mode", 32'(mode_out), 32'd0);
        drive(1'b0);

        // 1, 2: nominal short and long
        send_pulse(6, 2, 1'b1);
        send_pulse(18, 2, 1'b1);
        check("good_after_two", 32'(good_cnt), 32'd2);

        // 3: tolerance sweep
        sizes = '{5, 7, 17, 19, 4, 12, 20};
        foreach (sizes[i]) send_pulse(sizes[i], 2, 1'b1);
        check("mode_hold_after_err", 32'(mode_out), 32'd1);
        check("good_after_sweep", 32'(good_cnt), 32'd6);

        // 4: saturation
        send_pulse(40, 2, 1'b1);
        check("sat_len", 32'(len), 32'(CNT_MAX));

        // 5: reset during cycle 3 of a pulse, released with cf high
        drive(1'b1);
        drive(1'b1);
        cf = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_good", 32'(good_cnt), 32'd0);
        check("async_len", 32'(len), 32'd0);
        @(negedge clk);
        apply_reset(1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            check("ignored_busy", 32'(busy), 32'd0);
        end
        drive(1'b0);
        drive(1'b0);
        send_pulse(6, 2, 1'b1);
        check("good_after_rst", 32'(good_cnt), 32'd1);

        // 6: back-to-back with single low cycle
        send_pulse(6, 1, 1'b1);
        send_pulse(18, 2, 1'b1);

        // 6b: cf held high across reset release
        cf = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1);
            check("armed_busy", 32'(busy), 32'd0);
        end
        drive(1'b0);
        send_pulse(18, 2, 1'b1);
        check("good_after_hold", 32'(good_cnt), 32'd1);

        // Randomized widths and gaps
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: w = $urandom_range(SHORT_LEN - 2, SHORT_LEN + 2);
                1: w = $urandom_range(LONG_LEN - 2, LONG_LEN + 2);
                default: w = $urandom_range(1, 40);
            endcase
            send_pulse(w, $urandom_range(1, 4), 1'b1);
        end

        // good_cnt wrap
        for (int n = 0; n < 260; n++) begin
            send_pulse((n % 2 == 0) ? SHORT_LEN : SHORT_LEN + TOL, 1, 1'b0);
        end

        repeat (4) drive(1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("valid_total", 32'(valid_seen), 32'(exp_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
